// File: rtl/fpaddsub_issue_collect.sv
// -----------------------------------------------------------------------------
// fpaddsub_issue_collect
//
// Valid/ready wrapper around the fixed-latency FPAddSub core, which has no
// handshake of its own. Operations are accepted upstream and forwarded to the
// core combinationally. A valid/tag delay line, matched to the core latency,
// marks which core outputs are real results. Those results are captured into a
// first-word-fall-through result FIFO. Credit-based backpressure keeps the
// number of in-flight plus buffered results within the FIFO depth, so a result
// is never dropped.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. The source holds its payload stable while
// valid is high and ready is low. in_ready depends only on registered state
// (and rst), never on in_valid or out_ready.
//
// Parameters
//   LATENCY  core cycles from operand sample edge to Z/Flags valid (>=1)
//   DEPTH    result FIFO entries (power of 2, >=2)
//   TAG_W    width of the user tag carried with each op
//
// Optional feature macro: STICKY_FLAGS_EN
//   defined   : sticky_flags accumulates the OR of popped flags until sticky_clr
//   undefined : sticky_flags is tied to 0 and sticky_clr is ignored
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        op request handshake
//   in_a, in_b, in_ctrl      operands and add(0)/subtract(1) select
//   in_tag                   user tag returned with the result
//   core_a, core_b, core_ctrl  combinational copies of in_a, in_b, in_ctrl
//   core_z, core_flags       core result, valid LATENCY cycles after sampling
//   out_valid/out_ready      result handshake (FWFT head of the FIFO)
//   out_z, out_flags, out_tag  result payload
//   sticky_clr, sticky_flags sticky exception flags (feature only)
// -----------------------------------------------------------------------------
module fpaddsub_issue_collect #(
  parameter int LATENCY = 11,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  output logic             core_ctrl,
  input  logic [31:0]      core_z,
  input  logic [4:0]       core_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  input  logic             sticky_clr,
  output logic [4:0]       sticky_flags
);

  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic               acc;
  logic               push;
  logic               pop;
  logic [LATENCY-1:0] vld_sr;
  logic [TAG_W-1:0]   tag_sr [LATENCY];
  logic [INF_W-1:0]   inflight;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [31:0]        credit_used;

  logic [31:0]        mem_z     [DEPTH];
  logic [4:0]         mem_flags [DEPTH];
  logic [TAG_W-1:0]   mem_tag   [DEPTH];

  // The core has no valid input: it always computes on whatever is presented.
  assign core_a    = in_a;
  assign core_b    = in_b;
  assign core_ctrl = in_ctrl;

  assign acc  = in_valid & in_ready;
  assign push = vld_sr[LATENCY-1];
  assign pop  = out_valid & out_ready;

  // Credit check on registered state only: a pop in this cycle frees its
  // slot for acceptance one cycle later, which keeps in_ready off the
  // out_ready combinational path.
  assign credit_used = 32'(inflight) + 32'(count);
  assign in_ready    = !rst && (credit_used < 32'(DEPTH));

  // Valid delay line; stage LATENCY-1 lines up with the core result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= acc;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Tag delay line carries no control meaning, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_sr[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      tag_sr[i] <= tag_sr[i-1];
    end
  end

  // Occupancy bookkeeping and FIFO pointers. Pointers wrap naturally because
  // DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + INF_W'(acc) - INF_W'(push);
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage. The credit scheme guarantees a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr]     <= core_z;
      mem_flags[wr_ptr] <= core_flags;
      mem_tag[wr_ptr]   <= tag_sr[LATENCY-1];
    end
  end

  // First-word-fall-through head.
  assign out_valid = (count != '0);
  assign out_z     = mem_z[rd_ptr];
  assign out_flags = mem_flags[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];

`ifdef STICKY_FLAGS_EN
  // Clear wins over a same-cycle pop; that pop's flags are not recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= '0;
    end else if (pop) begin
      sticky_flags <= sticky_flags | out_flags;
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 5'b0;
`endif

endmodule

// File: tb/tb_fpaddsub_issue_collect.sv
// -----------------------------------------------------------------------------
// tb_fpaddsub_issue_collect
//
// Bench for fpaddsub_issue_collect. A stand-in FPAddSub core (fixed LATENCY
// register pipeline) sits on the core_* ports; it returns exact IEEE results
// for the hand-written vectors and a deterministic mix of the operands for
// random traffic. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fpaddsub_issue_collect;

  localparam int LATENCY = 11;
  localparam int DEPTH   = 16;
  localparam int TAG_W   = 4;
  localparam int RW      = 32 + 5 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic             in_ctrl = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      core_a, core_b;
  logic             core_ctrl;
  logic [31:0]      core_z;
  logic [4:0]       core_flags;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_z;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             sticky_clr = 1'b0;
  logic [4:0]       sticky_flags;

  fpaddsub_issue_collect #(
    .LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .core_a(core_a), .core_b(core_b), .core_ctrl(core_ctrl),
    .core_z(core_z), .core_flags(core_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags), .out_tag(out_tag),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  // ---------------- stand-in core ----------------
  function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic ctrl);
    if (a == 32'h3F800000 && b == 32'h40000000 && !ctrl) return {32'h40400000, 5'b00000};
    if (a == 32'h40400000 && b == 32'h3F800000 &&  ctrl) return {32'h40000000, 5'b00000};
    if (a == 32'h7F800000 && b == 32'hFF800000 && !ctrl) return {32'h7FC00000, 5'b00010};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !ctrl) return {32'h7F800000, 5'b10001};
    return {a ^ {b[15:0], b[31:16]} ^ {31'b0, ctrl}, a[4:0] ^ b[9:5]};
  endfunction

  logic [36:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_a, core_b, core_ctrl);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign {core_z, core_flags} = core_pipe[LATENCY-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];
  logic sb_en = 1'b0;
  int pops = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc  = -1;
  int max_out = 0;
  logic [TAG_W-1:0] tag_ctr = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (exp_q.size() > max_out) max_out = exp_q.size();
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%0h (cycle %0d)", {out_z, out_flags, out_tag}, cyc);
        end else begin
          logic [RW-1:0] e;
          e = exp_q.pop_front();
          if ({out_z, out_flags, out_tag} !== e) begin
            bad++;
            $display("FAIL sb_result got=%0h exp=%0h (cycle %0d)",
                     {out_z, out_flags, out_tag}, e, cyc);
          end
        end
        pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
    end
  end

  // A push into a full FIFO would mean the credit scheme is broken.
  always @(negedge clk) begin
    if (!rst && dut.push) begin
      total++;
      if (int'(dut.count) == DEPTH) begin
        bad++;
        $display("FAIL push_full count=%0d (cycle %0d)", dut.count, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // rmode: 0 = out_ready high, 1 = out_ready low, 2 = random out_ready
  task automatic offer(input int cycles, input int max_ops, input int rmode,
                       output int accepted, output int stalls);
    accepted = 0;
    stalls   = 0;
    for (int k = 0; k < cycles && accepted < max_ops; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      in_ctrl  = 1'($urandom_range(0, 1));
      in_tag   = tag_ctr;
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({core_fn(in_a, in_b, in_ctrl), in_tag});
        accepted++;
        tag_ctr++;
      end else begin
        stalls++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_pop_stats();
    pops = 0;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             ctrl;
    logic [TAG_W-1:0] tag;
    logic [31:0]      z;
    logic [4:0]       flags;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc_n, stall_n, acc_cyc, waited, stale;
    logic seen;
    logic [4:0] flag_or;

    vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'd3,  32'h40400000, 5'b00000};
    vecs[1] = '{32'h40400000, 32'h3F800000, 1'b1, 4'd5,  32'h40000000, 5'b00000};
    vecs[2] = '{32'h7F800000, 32'hFF800000, 1'b0, 4'd9,  32'h7FC00000, 5'b00010};
    vecs[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd12, 32'h7F800000, 5'b10001};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),     64'd0);
    check("rst_out_valid", 64'(out_valid),    64'd0);
    check("rst_sticky",    64'(sticky_flags), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  64'(in_ready),  64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Single ops from the table, checked directly at the head of the FIFO.
    out_ready = 1'b1;
    flag_or = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = vecs[i].a; in_b = vecs[i].b; in_ctrl = vecs[i].ctrl; in_tag = vecs[i].tag;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL vec%0d_timeout no out_valid within 40 cycles", i);
      end else begin
        check($sformatf("vec%0d_latency", i), 64'(cyc - acc_cyc), 64'(LATENCY + 1));
        check($sformatf("vec%0d_z", i),     64'(out_z),     64'(vecs[i].z));
        check($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].flags));
        check($sformatf("vec%0d_tag", i),   64'(out_tag),   64'(vecs[i].tag));
      end
      flag_or = flag_or | vecs[i].flags;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("table_drained", 64'(out_valid), 64'd0);
`ifdef STICKY_FLAGS_EN
    check("sticky_or", 64'(sticky_flags), 64'(flag_or));
    check("sticky_nan", 64'(sticky_flags[1]), 64'd1);
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 64'(sticky_flags), 64'd0);
`else
    check("sticky_tied_off", 64'(sticky_flags), 64'd0);
`endif

    // Back-to-back: 20 ops, tags 0..15,0..3, full throughput.
    sb_en = 1'b1;
    tag_ctr = '0;
    clear_pop_stats();
    offer(40, 20, 0, acc_n, stall_n);
    check("b2b_accepted", 64'(acc_n),   64'd20);
    check("b2b_stalls",   64'(stall_n), 64'd0);
    drain(100);
    check("b2b_pops",       64'(pops), 64'd20);
    check("b2b_throughput", 64'(last_pop_cyc - first_pop_cyc), 64'd19);

    // Backpressure: consumer stalled, producer keeps offering.
    clear_pop_stats();
    offer(40, 40, 1, acc_n, stall_n);
    check("bp_accepted", 64'(acc_n), 64'(DEPTH));
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (LATENCY + 4) @(negedge clk);
    check("bp_still_low",  64'(in_ready),  64'd0);
    check("bp_out_valid",  64'(out_valid), 64'd1);
    drain(100);
    check("bp_pops", 64'(pops), 64'(DEPTH));
    @(negedge clk);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);

    // Reset with 3 buffered and 5 in flight.
    clear_pop_stats();
    offer(10, 3, 1, acc_n, stall_n);
    repeat (LATENCY + 3) @(posedge clk);
    offer(10, 5, 1, acc_n, stall_n);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst2_no_stale", 64'(stale), 64'd0);
    offer(10, 1, 0, acc_n, stall_n);
    drain(40);
    check("rst2_fresh_pops", 64'(pops), 64'd1);

    // Pointer wrap with random consumer readiness.
    clear_pop_stats();
    max_out = 0;
    offer(2000, 100, 2, acc_n, stall_n);
    check("wrap_accepted", 64'(acc_n), 64'd100);
    drain(300);
    check("wrap_pops", 64'(pops), 64'd100);
    total++;
    if (max_out > DEPTH) begin
      bad++;
      $display("FAIL wrap_occupancy got=%0d limit=%0d", max_out, DEPTH);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
